// File: rtl/fb_port_arbiter_if.sv
// Requester and framebuffer port-A signal bundle for fb_port_arbiter.
// slave = arbiter side, master = requesters/RAM side.
interface fb_port_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 12
);
   logic              vblank;
   logic              r1_vblank_only;

   logic              r0_req;
   logic              r0_we;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic              r0_gnt;
   logic              r0_rvalid;
   logic [DATA_W-1:0] r0_rdata;

   logic              r1_req;
   logic              r1_we;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic              r1_gnt;
   logic              r1_rvalid;
   logic [DATA_W-1:0] r1_rdata;

   logic              fb_en;
   logic              fb_we;
   logic [ADDR_W-1:0] fb_addr;
   logic [DATA_W-1:0] fb_wdata;
   logic [DATA_W-1:0] fb_rdata;
   logic              range_err;

   modport slave (
      input  vblank, r1_vblank_only,
      input  r0_req, r0_we, r0_addr, r0_wdata,
      output r0_gnt, r0_rvalid, r0_rdata,
      input  r1_req, r1_we, r1_addr, r1_wdata,
      output r1_gnt, r1_rvalid, r1_rdata,
      output fb_en, fb_we, fb_addr, fb_wdata,
      input  fb_rdata,
      output range_err
   );

   modport master (
      output vblank, r1_vblank_only,
      output r0_req, r0_we, r0_addr, r0_wdata,
      input  r0_gnt, r0_rvalid, r0_rdata,
      output r1_req, r1_we, r1_addr, r1_wdata,
      input  r1_gnt, r1_rvalid, r1_rdata,
      input  fb_en, fb_we, fb_addr, fb_wdata,
      output fb_rdata,
      input  range_err
   );
endinterface

// File: rtl/fb_port_arbiter.sv
// Round-robin arbiter sharing framebuffer port A between the CPU bridge (r0)
// and the blitter (r1), with optional vblank-only gating of r1.
module fb_port_arbiter #(
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 12,
   parameter int FB_DEPTH = 76800
) (
   input logic               clock,
   input logic               reset,
   fb_port_arbiter_if.slave  bus
);
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(FB_DEPTH);

   logic              e0, e1;
   logic              gnt0, gnt1;
   logic              accept;
   logic              last_grant;

   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_in_range;

   logic              fb_en_q, fb_we_q, range_err_q;
   logic [ADDR_W-1:0] fb_addr_q;
   logic [DATA_W-1:0] fb_wdata_q;

   // read-return tag pipeline: {valid_read, id, oob}
   logic              s1_valid, s1_id, s1_oob;
   logic              s2_valid, s2_id, s2_oob;

   always_comb begin
      e0   = bus.r0_req;
      e1   = bus.r1_req && (!bus.r1_vblank_only || bus.vblank);
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         // on a tie, whoever was not granted last wins (last_grant = id of last winner)
         if (e0 && e1) begin
            gnt0 = last_grant;
            gnt1 = !last_grant;
         end else begin
            gnt0 = e0;
            gnt1 = e1;
         end
      end
   end

   assign accept = gnt0 || gnt1;

   always_comb begin
      if (gnt1) begin
         a_we    = bus.r1_we;
         a_addr  = bus.r1_addr;
         a_wdata = bus.r1_wdata;
      end else begin
         a_we    = bus.r0_we;
         a_addr  = bus.r0_addr;
         a_wdata = bus.r0_wdata;
      end
      a_in_range = {1'b0, a_addr} < DEPTH;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant  <= 1'b1;
         fb_en_q     <= 1'b0;
         fb_we_q     <= 1'b0;
         fb_addr_q   <= '0;
         fb_wdata_q  <= '0;
         range_err_q <= 1'b0;
         s1_valid    <= 1'b0;
         s1_id       <= 1'b0;
         s1_oob      <= 1'b0;
         s2_valid    <= 1'b0;
         s2_id       <= 1'b0;
         s2_oob      <= 1'b0;
      end else begin
         fb_en_q     <= accept;
         fb_we_q     <= accept && a_we && a_in_range;
         range_err_q <= accept && !a_in_range;
         if (accept) begin
            last_grant <= gnt1;
            fb_addr_q  <= a_addr;
            fb_wdata_q <= a_wdata;
         end
         s1_valid <= accept && !a_we;
         s1_id    <= gnt1;
         s1_oob   <= accept && !a_in_range;
         s2_valid <= s1_valid;
         s2_id    <= s1_id;
         s2_oob   <= s1_oob;
      end
   end

   assign bus.r0_gnt    = gnt0;
   assign bus.r1_gnt    = gnt1;
   assign bus.fb_en     = fb_en_q;
   assign bus.fb_we     = fb_we_q;
   assign bus.fb_addr   = fb_addr_q;
   assign bus.fb_wdata  = fb_wdata_q;
   assign bus.range_err = range_err_q;

   assign bus.r0_rvalid = s2_valid && !s2_id;
   assign bus.r1_rvalid = s2_valid &&  s2_id;
   // out-of-range reads return zero instead of whatever the RAM drives
   assign bus.r0_rdata  = (s2_valid && !s2_id && !s2_oob) ? bus.fb_rdata : '0;
   assign bus.r1_rdata  = (s2_valid &&  s2_id && !s2_oob) ? bus.fb_rdata : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter with a behavioural
// 1-cycle-latency framebuffer RAM on port A.
module tb_fb_port_arbiter;
   logic clock;
   logic reset;
   int   passed;
   int   total;

   fb_port_arbiter_if #(.ADDR_W(17), .DATA_W(12)) bus ();

   fb_port_arbiter #(.ADDR_W(17), .DATA_W(12), .FB_DEPTH(76800)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [11:0] mem [0:76799];

   function automatic logic [11:0] init_val(input int a);
      return 12'(a) ^ 12'h5A5;
   endfunction

   // out-of-range reads drive a nonzero pattern so zero-forcing is observable
   always @(posedge clock) begin
      if (bus.fb_en) begin
         if (bus.fb_addr < 17'd76800) begin
            bus.fb_rdata <= mem[bus.fb_addr];
            if (bus.fb_we) mem[bus.fb_addr] <= bus.fb_wdata;
         end else begin
            bus.fb_rdata <= 12'hEEE;
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_r0(input logic req, input logic we, input logic [16:0] addr, input logic [11:0] wd);
      bus.r0_req = req; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wd;
   endtask

   task automatic set_r1(input logic req, input logic we, input logic [16:0] addr, input logic [11:0] wd);
      bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wd;
   endtask

   task automatic test_reset();
      set_r0(1'b1, 1'b0, 17'd5, 12'h0);
      set_r1(1'b1, 1'b0, 17'd6, 12'h0);
      step(); step();
      @(negedge clock);
      total++; if (bus.r0_gnt !== 1'b0) $display("FAIL rst_gnt0: got %b want 0", bus.r0_gnt); else passed++;
      total++; if (bus.r1_gnt !== 1'b0) $display("FAIL rst_gnt1: got %b want 0", bus.r1_gnt); else passed++;
      total++; if ({bus.fb_en, bus.fb_we, bus.range_err} !== 3'b000) $display("FAIL rst_ctl: got %b want 000", {bus.fb_en, bus.fb_we, bus.range_err}); else passed++;
      total++; if ({bus.fb_addr, bus.fb_wdata} !== 29'd0) $display("FAIL rst_bus: got %h want 0", {bus.fb_addr, bus.fb_wdata}); else passed++;
      total++; if ({bus.r0_rvalid, bus.r1_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {bus.r0_rvalid, bus.r1_rvalid}); else passed++;
      set_r0(1'b0, 1'b0, 17'd0, 12'h0);
      set_r1(1'b0, 1'b0, 17'd0, 12'h0);
      step();
      reset = 1'b0;
   endtask

   task automatic test_write_read();
      set_r0(1'b1, 1'b1, 17'd100, 12'hABC);
      @(negedge clock);
      total++; if (bus.r0_gnt !== 1'b1) $display("FAIL wr_gnt0: got %b want 1", bus.r0_gnt); else passed++;
      step();
      set_r0(1'b1, 1'b0, 17'd100, 12'h000);
      @(negedge clock);
      total++; if ({bus.fb_en, bus.fb_we} !== 2'b11) $display("FAIL wr_en_we: got %b want 11", {bus.fb_en, bus.fb_we}); else passed++;
      total++; if (bus.fb_addr !== 17'd100 || bus.fb_wdata !== 12'hABC) $display("FAIL wr_bus: got %0d/%h want 100/abc", bus.fb_addr, bus.fb_wdata); else passed++;
      total++; if (bus.r0_gnt !== 1'b1) $display("FAIL rd_gnt0: got %b want 1", bus.r0_gnt); else passed++;
      step();
      set_r0(1'b0, 1'b0, 17'd0, 12'h0);
      @(negedge clock);
      total++; if ({bus.fb_en, bus.fb_we} !== 2'b10) $display("FAIL rd_en_we: got %b want 10", {bus.fb_en, bus.fb_we}); else passed++;
      total++; if (bus.r0_rvalid !== 1'b0) $display("FAIL rd_early_rvalid: got %b want 0", bus.r0_rvalid); else passed++;
      step();
      @(negedge clock);
      total++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== 12'hABC) $display("FAIL rd_ret: got %b/%h want 1/abc", bus.r0_rvalid, bus.r0_rdata); else passed++;
      total++; if (bus.r1_rvalid !== 1'b0) $display("FAIL rd_r1_quiet: got %b want 0", bus.r1_rvalid); else passed++;
      step();
      @(negedge clock);
      total++; if (bus.r0_rvalid !== 1'b0) $display("FAIL rd_pulse: got %b want 0", bus.r0_rvalid); else passed++;
      step();
   endtask

   task automatic test_fairness();
      int n0, n1;
      n0 = 0; n1 = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_r0(1'b1, 1'b0, 17'd200, 12'h0);
      set_r1(1'b1, 1'b0, 17'd300, 12'h0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (bus.r0_gnt) n0++;
         if (bus.r1_gnt) n1++;
         total++; if (bus.r0_gnt !== (i % 2 == 0) || bus.r1_gnt !== (i % 2 == 1)) $display("FAIL rr_gnt[%0d]: got %b%b want %b%b", i, bus.r0_gnt, bus.r1_gnt, (i % 2 == 0), (i % 2 == 1)); else passed++;
         if (i >= 1) begin
            total++; if (bus.fb_en !== 1'b1 || bus.fb_addr !== ((i % 2 == 1) ? 17'd200 : 17'd300)) $display("FAIL rr_addr[%0d]: got %b/%0d", i, bus.fb_en, bus.fb_addr); else passed++;
         end
         if (i >= 2) begin
            total++; if (bus.r0_rvalid !== (i % 2 == 0) || bus.r1_rvalid !== (i % 2 == 1)) $display("FAIL rr_rvalid[%0d]: got %b%b", i, bus.r0_rvalid, bus.r1_rvalid); else passed++;
            total++; if ((i % 2 == 0 ? bus.r0_rdata : bus.r1_rdata) !== init_val(i % 2 == 0 ? 200 : 300)) $display("FAIL rr_rdata[%0d]: got %h/%h", i, bus.r0_rdata, bus.r1_rdata); else passed++;
         end
         step();
      end
      set_r0(1'b0, 1'b0, 17'd0, 12'h0);
      set_r1(1'b0, 1'b0, 17'd0, 12'h0);
      total++; if (n0 !== 4 || n1 !== 4) $display("FAIL rr_counts: got %0d/%0d want 4/4", n0, n1); else passed++;
      @(negedge clock);
      total++; if (bus.fb_addr !== 17'd300) $display("FAIL rr_last_addr: got %0d want 300", bus.fb_addr); else passed++;
      step();
      @(negedge clock);
      total++; if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== init_val(300)) $display("FAIL rr_tail: got %b/%h want 1/%h", bus.r1_rvalid, bus.r1_rdata, init_val(300)); else passed++;
      step();
   endtask

   task automatic test_vblank();
      bus.r1_vblank_only = 1'b1;
      bus.vblank = 1'b0;
      set_r1(1'b1, 1'b0, 17'd400, 12'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         total++; if (bus.r1_gnt !== 1'b0) $display("FAIL vb_block[%0d]: got %b want 0", i, bus.r1_gnt); else passed++;
         step();
      end
      bus.vblank = 1'b1;
      @(negedge clock);
      total++; if (bus.r1_gnt !== 1'b1) $display("FAIL vb_rise: got %b want 1", bus.r1_gnt); else passed++;
      total++; if (bus.fb_en !== 1'b0) $display("FAIL vb_idle_en: got %b want 0", bus.fb_en); else passed++;
      step();
      set_r1(1'b1, 1'b0, 17'd401, 12'h0);
      @(negedge clock);
      total++; if (bus.r1_gnt !== 1'b1 || bus.fb_addr !== 17'd400) $display("FAIL vb_burst: got %b/%0d want 1/400", bus.r1_gnt, bus.fb_addr); else passed++;
      step();
      bus.vblank = 1'b0;
      @(negedge clock);
      total++; if (bus.r1_gnt !== 1'b0) $display("FAIL vb_fall: got %b want 0", bus.r1_gnt); else passed++;
      total++; if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== init_val(400)) $display("FAIL vb_ret0: got %b/%h want 1/%h", bus.r1_rvalid, bus.r1_rdata, init_val(400)); else passed++;
      step();
      bus.r1_vblank_only = 1'b0;
      set_r1(1'b1, 1'b0, 17'd402, 12'h0);
      @(negedge clock);
      total++; if (bus.r1_gnt !== 1'b1) $display("FAIL vb_only_off: got %b want 1", bus.r1_gnt); else passed++;
      total++; if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== init_val(401)) $display("FAIL vb_ret1: got %b/%h want 1/%h", bus.r1_rvalid, bus.r1_rdata, init_val(401)); else passed++;
      total++; if (bus.fb_en !== 1'b0) $display("FAIL vb_gap_en: got %b want 0", bus.fb_en); else passed++;
      step();
      set_r1(1'b0, 1'b0, 17'd0, 12'h0);
      @(negedge clock);
      total++; if (bus.r1_rvalid !== 1'b0 || bus.fb_addr !== 17'd402) $display("FAIL vb_gap: got %b/%0d want 0/402", bus.r1_rvalid, bus.fb_addr); else passed++;
      step();
      @(negedge clock);
      total++; if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== init_val(402)) $display("FAIL vb_ret2: got %b/%h want 1/%h", bus.r1_rvalid, bus.r1_rdata, init_val(402)); else passed++;
      step();
   endtask

   task automatic test_out_of_range();
      set_r1(1'b1, 1'b1, 17'd76799, 12'h123);
      @(negedge clock);
      total++; if (bus.r1_gnt !== 1'b1) $display("FAIL oob_gnt_a: got %b want 1", bus.r1_gnt); else passed++;
      step();
      set_r1(1'b1, 1'b1, 17'd76800, 12'hFFF);
      @(negedge clock);
      total++; if (bus.r1_gnt !== 1'b1) $display("FAIL oob_gnt_w: got %b want 1", bus.r1_gnt); else passed++;
      total++; if (bus.fb_we !== 1'b1 || bus.range_err !== 1'b0) $display("FAIL oob_edge_wr: got we %b err %b want 1/0", bus.fb_we, bus.range_err); else passed++;
      step();
      set_r1(1'b1, 1'b0, 17'd76800, 12'h0);
      @(negedge clock);
      total++; if (bus.r1_gnt !== 1'b1) $display("FAIL oob_gnt_r: got %b want 1", bus.r1_gnt); else passed++;
      total++; if ({bus.fb_en, bus.fb_we, bus.range_err} !== 3'b101 || bus.fb_addr !== 17'd76800) $display("FAIL oob_wr_sup: got %b/%0d want 101/76800", {bus.fb_en, bus.fb_we, bus.range_err}, bus.fb_addr); else passed++;
      step();
      set_r1(1'b1, 1'b0, 17'd76799, 12'h0);
      @(negedge clock);
      total++; if ({bus.fb_en, bus.fb_we, bus.range_err} !== 3'b101) $display("FAIL oob_rd_err: got %b want 101", {bus.fb_en, bus.fb_we, bus.range_err}); else passed++;
      step();
      set_r1(1'b0, 1'b0, 17'd0, 12'h0);
      @(negedge clock);
      total++; if (bus.range_err !== 1'b0) $display("FAIL oob_err_end: got %b want 0", bus.range_err); else passed++;
      total++; if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== 12'h000) $display("FAIL oob_rd_zero: got %b/%h want 1/000", bus.r1_rvalid, bus.r1_rdata); else passed++;
      step();
      @(negedge clock);
      total++; if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== 12'h123) $display("FAIL oob_neighbour: got %b/%h want 1/123", bus.r1_rvalid, bus.r1_rdata); else passed++;
      step();
   endtask

   task automatic test_interleaved();
      set_r0(1'b1, 1'b0, 17'd100, 12'h0);
      set_r1(1'b1, 1'b0, 17'd400, 12'h0);
      @(negedge clock);
      total++; if ({bus.r0_gnt, bus.r1_gnt} !== 2'b10) $display("FAIL il_tie: got %b want 10", {bus.r0_gnt, bus.r1_gnt}); else passed++;
      step();
      set_r0(1'b0, 1'b0, 17'd0, 12'h0);
      @(negedge clock);
      total++; if ({bus.r0_gnt, bus.r1_gnt} !== 2'b01) $display("FAIL il_second: got %b want 01", {bus.r0_gnt, bus.r1_gnt}); else passed++;
      step();
      set_r1(1'b0, 1'b0, 17'd0, 12'h0);
      @(negedge clock);
      total++; if ({bus.r0_rvalid, bus.r1_rvalid} !== 2'b10 || bus.r0_rdata !== 12'hABC) $display("FAIL il_ret0: got %b/%h want 10/abc", {bus.r0_rvalid, bus.r1_rvalid}, bus.r0_rdata); else passed++;
      step();
      @(negedge clock);
      total++; if ({bus.r0_rvalid, bus.r1_rvalid} !== 2'b01 || bus.r1_rdata !== init_val(400)) $display("FAIL il_ret1: got %b/%h want 01/%h", {bus.r0_rvalid, bus.r1_rvalid}, bus.r1_rdata, init_val(400)); else passed++;
      step();
      @(negedge clock);
      total++; if ({bus.r0_rvalid, bus.r1_rvalid} !== 2'b00) $display("FAIL il_quiet: got %b want 00", {bus.r0_rvalid, bus.r1_rvalid}); else passed++;
      step();
   endtask

   task automatic test_reset_mid();
      set_r0(1'b1, 1'b0, 17'd100, 12'h0);
      @(negedge clock);
      total++; if (bus.r0_gnt !== 1'b1) $display("FAIL mr_gnt: got %b want 1", bus.r0_gnt); else passed++;
      step();
      reset = 1'b1;
      set_r0(1'b1, 1'b0, 17'd500, 12'h0);
      set_r1(1'b1, 1'b0, 17'd600, 12'h0);
      @(negedge clock);
      total++; if ({bus.r0_gnt, bus.r1_gnt} !== 2'b00) $display("FAIL mr_gnt_rst: got %b want 00", {bus.r0_gnt, bus.r1_gnt}); else passed++;
      step();
      @(negedge clock);
      total++; if ({bus.fb_en, bus.fb_we, bus.range_err, bus.r0_rvalid, bus.r1_rvalid} !== 5'b0) $display("FAIL mr_ctl: got %b want 00000", {bus.fb_en, bus.fb_we, bus.range_err, bus.r0_rvalid, bus.r1_rvalid}); else passed++;
      total++; if ({bus.fb_addr, bus.fb_wdata, bus.r0_rdata, bus.r1_rdata} !== 53'd0) $display("FAIL mr_bus: got %h want 0", {bus.fb_addr, bus.fb_wdata, bus.r0_rdata, bus.r1_rdata}); else passed++;
      step();
      reset = 1'b0;
      @(negedge clock);
      total++; if ({bus.r0_gnt, bus.r1_gnt} !== 2'b10) $display("FAIL mr_tie: got %b want 10", {bus.r0_gnt, bus.r1_gnt}); else passed++;
      total++; if ({bus.r0_rvalid, bus.r1_rvalid} !== 2'b00) $display("FAIL mr_no_rvalid: got %b want 00", {bus.r0_rvalid, bus.r1_rvalid}); else passed++;
      step();
      set_r0(1'b0, 1'b0, 17'd0, 12'h0);
      set_r1(1'b0, 1'b0, 17'd0, 12'h0);
      @(negedge clock);
      total++; if (bus.fb_en !== 1'b1 || bus.fb_addr !== 17'd500) $display("FAIL mr_first: got %b/%0d want 1/500", bus.fb_en, bus.fb_addr); else passed++;
      step(); step(); step();
   endtask

   initial begin
      passed = 0;
      total  = 0;
      for (int a = 0; a < 76800; a++) mem[a] = init_val(a);
      bus.fb_rdata       = 12'h000;
      bus.vblank         = 1'b0;
      bus.r1_vblank_only = 1'b0;
      reset = 1'b1;
      set_r0(1'b0, 1'b0, 17'd0, 12'h0);
      set_r1(1'b0, 1'b0, 17'd0, 12'h0);
      #1;
      test_reset();
      test_write_read();
      test_fairness();
      test_vblank();
      test_out_of_range();
      test_interleaved();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
